// File: rtl/stepper_sequencer.sv
// Stepper motor sequencer: external STEP/DIR or internal rate-generated moves to an
// absolute target, with wave/full/half coil sequencing and a wrapping position counter.
module stepper_sequencer #(
  parameter int POS_WIDTH = 32,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ext_mode,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic [POS_WIDTH-1:0] target,
  input  logic                 move_start,
  output logic                 busy,
  output logic                 done,
  output logic                 step_pulse,
  output logic [POS_WIDTH-1:0] position,
  output logic [3:0]           coils
);

  localparam logic [DIV_WIDTH-1:0] ONE_DIV = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0] ONE_POS = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_next;
  logic [2:0]           ph, ph_next, ph_delta;
  logic [POS_WIDTH-1:0] position_next, target_lat, diff, pos_inc, pos_dec, run_pos;
  logic [DIV_WIDTH-1:0] rate_cnt, rate_next, period_eff;
  logic                 step_prev, ext_event, run_up;
  logic                 do_step, step_up, load_target, busy_next, done_next;
  logic [3:0]           coils_next;

  function automatic logic [3:0] half_table(input logic [2:0] idx);
    case (idx)
      3'd0:    half_table = 4'b1000;
      3'd1:    half_table = 4'b1100;
      3'd2:    half_table = 4'b0100;
      3'd3:    half_table = 4'b0110;
      3'd4:    half_table = 4'b0010;
      3'd5:    half_table = 4'b0011;
      3'd6:    half_table = 4'b0001;
      default: half_table = 4'b1001;
    endcase
  endfunction

  assign period_eff = (period == '0) ? ONE_DIV : period;
  assign pos_inc    = position + ONE_POS;
  assign pos_dec    = position - ONE_POS;
  // Sign of the modular distance picks the short path, including across the wrap.
  assign diff       = target_lat - position;
  assign run_up     = ~diff[POS_WIDTH-1];
  assign run_pos    = run_up ? pos_inc : pos_dec;
  assign ext_event  = step_in & ~step_prev & ext_mode & en & (state == IDLE);
  assign ph_delta   = (mode == 2'b10) ? 3'd1 : 3'd2;

  always_comb begin
    state_next  = state;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    do_step     = 1'b0;
    step_up     = dir_in;
    load_target = 1'b0;
    rate_next   = rate_cnt;
    case (state)
      IDLE: begin
        if (ext_event) do_step = 1'b1;
        if (move_start && en && !ext_mode) begin
          load_target = 1'b1;
          rate_next   = '0;
          if (target == position) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
            busy_next  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!en || ext_mode) begin
          state_next = IDLE;
        end else begin
          busy_next = 1'b1;
          step_up   = run_up;
          if (rate_cnt >= period_eff - ONE_DIV) begin
            rate_next = '0;
            do_step   = 1'b1;
            if (run_pos == target_lat) begin
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            rate_next = rate_cnt + ONE_DIV;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    position_next = position;
    ph_next       = ph;
    if (do_step) begin
      position_next = step_up ? pos_inc : pos_dec;
      ph_next       = step_up ? ph + ph_delta : ph - ph_delta;
    end

    // Coils are decoded from the post-step phase so they land together with the step.
    coils_next = 4'b0000;
    if (en) begin
      case (mode)
        2'b00:   coils_next = half_table({ph_next[2:1], 1'b0});
        2'b01:   coils_next = half_table({ph_next[2:1], 1'b1});
        2'b10:   coils_next = half_table(ph_next);
        default: coils_next = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ph         <= 3'd0;
      position   <= '0;
      target_lat <= '0;
      rate_cnt   <= '0;
      step_prev  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_pulse <= 1'b0;
      coils      <= 4'b0000;
    end else begin
      state      <= state_next;
      ph         <= ph_next;
      position   <= position_next;
      rate_cnt   <= rate_next;
      step_prev  <= step_in;
      busy       <= busy_next;
      done       <= done_next;
      step_pulse <= do_step;
      coils      <= coils_next;
      if (load_target) target_lat <= target;
    end
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Scoreboard bench for stepper_sequencer: a 32-bit and an 8-bit position instance share
// identical stimulus; step/done events are popped from a queue of expected responses.
module tb_stepper_sequencer;

  typedef struct {
    logic        sp;
    logic        dn;
    logic        bz;
    logic [31:0] pos;
    logic [3:0]  cl;
  } exp_t;

  logic        clk;
  logic        rst, en, ext_mode, step_in, dir_in, move_start;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [31:0] target;

  logic        busy32, done32, sp32;
  logic [31:0] pos32;
  logic [3:0]  coils32;
  logic        busy8, done8, sp8;
  logic [7:0]  pos8;
  logic [3:0]  coils8;

  exp_t sbq[$];
  int   vectors;
  int   miscompares;

  stepper_sequencer dut32 (
    .clk(clk), .rst(rst), .en(en), .ext_mode(ext_mode), .step_in(step_in),
    .dir_in(dir_in), .mode(mode), .period(period), .target(target),
    .move_start(move_start), .busy(busy32), .done(done32), .step_pulse(sp32),
    .position(pos32), .coils(coils32)
  );

  stepper_sequencer #(.POS_WIDTH(8), .DIV_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .en(en), .ext_mode(ext_mode), .step_in(step_in),
    .dir_in(dir_in), .mode(mode), .period(period), .target(target[7:0]),
    .move_start(move_start), .busy(busy8), .done(done8), .step_pulse(sp8),
    .position(pos8), .coils(coils8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [38:0] act, input logic [38:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got {sp,done,busy,pos,coils}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expectEvent(input logic sp, input logic dn, input logic bz,
                             input logic [31:0] pos, input logic [3:0] cl);
    exp_t e;
    e.sp = sp; e.dn = dn; e.bz = bz; e.pos = pos; e.cl = cl;
    sbq.push_back(e);
  endtask

  // One external step pulse; counted pulses queue the response they should produce.
  task automatic applyStimulus(input logic dir, input logic [31:0] pos,
                               input logic [3:0] cl, input logic counted);
    dir_in  = dir;
    step_in = 1'b1;
    if (counted) expectEvent(1'b1, 1'b0, 1'b0, pos, cl);
    tick(1);
    step_in = 1'b0;
    tick(1);
  endtask

  task automatic checkOutput(input string name, input logic bz, input logic dn, input logic sp,
                             input logic [31:0] pos, input logic [3:0] cl);
    compare({name, "/w32"}, {sp32, done32, busy32, pos32, coils32}, {sp, dn, bz, pos, cl});
    compare({name, "/w8"}, {sp8, done8, busy8, 24'd0, pos8, coils8},
            {sp, dn, bz, 24'd0, pos[7:0], cl});
  endtask

  // Monitor: every step or done seen on either instance consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sp32 || done32 || sp8 || done8) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_event: got sp32=%b done32=%b sp8=%b done8=%b pos32=%h required no event",
                   sp32, done32, sp8, done8, pos32);
        end else begin
          e = sbq.pop_front();
          compare("event/w32", {sp32, done32, busy32, pos32, coils32}, {e.sp, e.dn, e.bz, e.pos, e.cl});
          compare("event/w8", {sp8, done8, busy8, 24'd0, pos8, coils8},
                  {e.sp, e.dn, e.bz, 24'd0, e.pos[7:0], e.cl});
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; en = 1'b1; ext_mode = 1'b1; step_in = 1'b0; dir_in = 1'b1;
    mode = 2'b01; period = 16'd0; target = 32'd0; move_start = 1'b0;
    tick(2);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 32'd0, 4'b0000);

    // External full-step, forward
    rst = 1'b0;
    tick(1);
    checkOutput("full_idle", 1'b0, 1'b0, 1'b0, 32'd0, 4'b1100);
    applyStimulus(1'b1, 32'd1, 4'b0110, 1'b1);
    applyStimulus(1'b1, 32'd2, 4'b0011, 1'b1);
    applyStimulus(1'b1, 32'd3, 4'b1001, 1'b1);
    applyStimulus(1'b1, 32'd4, 4'b1100, 1'b1);
    checkOutput("full_end", 1'b0, 1'b0, 1'b0, 32'd4, 4'b1100);

    // External half-step, reverse, then steps while disabled
    rst = 1'b1; mode = 2'b10; dir_in = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("half_idle", 1'b0, 1'b0, 1'b0, 32'd0, 4'b1000);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 4'b1001, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFE, 4'b0001, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFD, 4'b0011, 1'b1);
    en = 1'b0;
    tick(1);
    checkOutput("en_off", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 4'b0000);
    applyStimulus(1'b0, 32'd0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 32'd0, 4'b0000, 1'b0);
    checkOutput("en_off_steps", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 4'b0000);
    en = 1'b1;
    tick(1);
    checkOutput("en_on", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 4'b0011);

    // Internal move 0 -> 3 at period 5, with an ignored restart mid-move
    rst = 1'b1; mode = 2'b01; ext_mode = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    period = 16'd5; target = 32'd3;
    expectEvent(1'b1, 1'b0, 1'b1, 32'd1, 4'b0110);
    expectEvent(1'b1, 1'b0, 1'b1, 32'd2, 4'b0011);
    expectEvent(1'b1, 1'b1, 1'b0, 32'd3, 4'b1001);
    move_start = 1'b1;
    tick(1);
    move_start = 1'b0;
    checkOutput("move_busy", 1'b1, 1'b0, 1'b0, 32'd0, 4'b1100);
    target = 32'd100; move_start = 1'b1;
    tick(1);
    move_start = 1'b0; target = 32'd3;
    tick(14);
    checkOutput("move_done", 1'b0, 1'b1, 1'b1, 32'd3, 4'b1001);
    tick(1);
    checkOutput("move_after", 1'b0, 1'b0, 1'b0, 32'd3, 4'b1001);

    // Zero-length move
    expectEvent(1'b0, 1'b1, 1'b0, 32'd3, 4'b1001);
    move_start = 1'b1;
    tick(1);
    move_start = 1'b0;
    checkOutput("zero_done", 1'b0, 1'b1, 1'b0, 32'd3, 4'b1001);
    tick(1);
    checkOutput("zero_after", 1'b0, 1'b0, 1'b0, 32'd3, 4'b1001);

    // Abort by en=0 after one step
    period = 16'd4; target = 32'd10;
    expectEvent(1'b1, 1'b0, 1'b1, 32'd4, 4'b1100);
    move_start = 1'b1;
    tick(1);
    move_start = 1'b0;
    tick(4);
    checkOutput("abort_step", 1'b1, 1'b0, 1'b1, 32'd4, 4'b1100);
    en = 1'b0;
    tick(1);
    checkOutput("abort", 1'b0, 1'b0, 1'b0, 32'd4, 4'b0000);
    tick(6);
    checkOutput("abort_frozen", 1'b0, 1'b0, 1'b0, 32'd4, 4'b0000);
    en = 1'b1;
    tick(1);
    checkOutput("abort_resume", 1'b0, 1'b0, 1'b0, 32'd4, 4'b1100);
    tick(8);
    checkOutput("abort_idle", 1'b0, 1'b0, 1'b0, 32'd4, 4'b1100);

    // Reset in the middle of a move
    period = 16'd3; target = 32'd7;
    move_start = 1'b1;
    tick(1);
    move_start = 1'b0;
    checkOutput("rst_mid_busy", 1'b1, 1'b0, 1'b0, 32'd4, 4'b1100);
    tick(1);
    rst = 1'b1;
    tick(1);
    checkOutput("rst_mid", 1'b0, 1'b0, 1'b0, 32'd0, 4'b0000);
    rst = 1'b0;

    // Walk back to -6 (250 on the 8-bit instance), then move to 2 across the wrap at period 0
    mode = 2'b10; ext_mode = 1'b1; dir_in = 1'b0; period = 16'd0;
    tick(1);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 4'b1001, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFE, 4'b0001, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFD, 4'b0011, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 4'b0010, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFB, 4'b0110, 1'b1);
    applyStimulus(1'b0, 32'hFFFF_FFFA, 4'b0100, 1'b1);
    checkOutput("wrap_start", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFA, 4'b0100);
    expectEvent(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB, 4'b0110);
    expectEvent(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'b0010);
    expectEvent(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 4'b0011);
    expectEvent(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0001);
    expectEvent(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1001);
    expectEvent(1'b1, 1'b0, 1'b1, 32'd0, 4'b1000);
    expectEvent(1'b1, 1'b0, 1'b1, 32'd1, 4'b1100);
    expectEvent(1'b1, 1'b1, 1'b0, 32'd2, 4'b0100);
    target = 32'd2; ext_mode = 1'b0; move_start = 1'b1;
    tick(1);
    move_start = 1'b0;
    tick(8);
    checkOutput("wrap_done", 1'b0, 1'b1, 1'b1, 32'd2, 4'b0100);
    tick(3);

    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missing_events: got %0d expected events never seen, required 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stepper_sequencer.md
# stepper_sequencer

Parametrised successor to the fixed full-step motor driver. It accepts external STEP/DIR pulses or runs an internal rate-generated move to an absolute target position. It supports wave, full-step and half-step coil sequencing, and tracks a wrap-around position counter of configurable width. It sits between the top-level IO pads and the 4-wire coil driver outputs.

## Interface
Parameters:
- POS_WIDTH, 32: width of position and target (two's-complement, wraps mod 2^POS_WIDTH)
- DIV_WIDTH, 16: width of internal step-period divider

Ports:
- clk  in  1  single clock for all state
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = driver active; 0 = coils off, steps ignored, move aborted
- ext_mode  in  1  1 = external STEP/DIR control; 0 = internal move generator
- step_in  in  1  external step; rising edge = one step (ext_mode=1 only)
- dir_in  in  1  external direction; 1 = +1, 0 = -1
- mode  in  2  00 wave, 01 full, 10 half, 11 coils off (steps still tracked)
- period  in  DIV_WIDTH  clocks per internal step; 0 treated as 1
- target  in  POS_WIDTH  absolute target for internal move
- move_start  in  1  1-cycle request; accepted only when !busy, en=1, ext_mode=0
- busy  out  1  internal move in progress
- done  out  1  1-cycle pulse on move completion
- step_pulse  out  1  1-cycle pulse per executed step
- position  out  POS_WIDTH  current step position
- coils  out  4  coil drive {A,B,C,D}

## Operation
- Phase index ph[2:0], half-step table: 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001.
- Coil decode: half uses table[ph]; wave uses table[{ph[2:1],0}]; full uses table[{ph[2:1],1}]; mode 11 or en=0 gives 0000.
- Per step: position ±1; ph ±1 in half mode, ±2 in wave/full (mod 8). Mode changes never alter ph.
- Edge detect: registered step_prev. A step event occurs when step_in=1 and step_prev=0, ext_mode=1, en=1. step_prev updates every cycle regardless of en.
- Internal FSM IDLE/RUN:
  - IDLE: accepted move_start latches target and clears the rate counter. If target==position, stay IDLE and pulse done. Otherwise go RUN.
  - RUN: the rate counter increments each cycle. At count period_eff-1 it clears and steps one toward target. Direction is the sign bit of (target_latched - position), computed mod 2^POS_WIDTH.
  - RUN exit: the step whose next position equals target goes to IDLE with busy<=0 and done<=1 on the same edge.
  - RUN abort: en=0 or ext_mode=1 returns to IDLE with no done and no step that cycle.
- In RUN, external steps, move_start and target changes are ignored (target is latched).
- period is sampled live each cycle, so changes mid-move take effect at the next comparison.

## Timing
- Reset values: position 0, ph 0, coils 0000, busy 0, done 0, step_pulse 0, step_prev 0, FSM IDLE.
- All outputs are registered. coils reflect ph, mode and en from the previous edge, so coils are 1100 one cycle after reset release in full mode.
- External step: the event in cycle N updates position and coils and pulses step_pulse at edge N+1 (1-cycle latency).
- Internal move: move_start sampled at edge k gives busy=1 after k. Steps land at edges k+P, k+2P, … where P = period_eff. The final step edge also drops busy and raises done.
- Zero-length move: done=1 for exactly one cycle after edge k; busy stays 0.
- Wrap: position 2^POS_WIDTH-1 +1 gives 0. Target across the wrap takes the short signed path.
- Reset mid-move: the next edge returns all state to reset values; no done.

## Test plan
- Reset, mode=01, en=1, ext_mode=1, dir_in=1, 4 step_in rising edges: position 1,2,3,4; coils 0110,0011,1001,1100; 4 step_pulses.
- mode=10, dir_in=0, 3 edges from reset: position -1,-2,-3 (0xFFFFFFFF…); coils 1001,0001,0011.
- ext_mode=0, period=5, target=3, move_start at edge k: steps at k+5, k+10, k+15; busy falls and done pulses at k+15; position=3.
- target=position with move_start: single-cycle done, busy never asserted. Repeat move_start while busy: ignored.
- Mid-move en=0: busy drops next edge, no done, coils 0000, position frozen. step_in edges with en=0 are not counted.
- POS_WIDTH=8, position=250, target=2: moves +8 steps through wrap (255 to 0) and ends at 2 with done.
